// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI engine arbiter and its clients.
package spi_arb_pkg;
  localparam int SPI_ADDR_W = 8;
  localparam int SPI_DATA_W = 8;

  // Register map entries also used by the IMU poller.
  localparam logic [SPI_ADDR_W-1:0] WHO_AM_I   = 8'h0F;
  localparam logic [SPI_ADDR_W-1:0] STATUS_REG = 8'h1E;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit after rr_ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  always_comb begin
    int cand;
    cand   = 0;
    winner = '0;
    valid  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % N_REQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one single-byte SPI engine between N_REQ requesters,
// with an enforced inter-transaction gap and a BUSY timeout.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*SPI_ADDR_W-1:0] req_addr,
  input  logic [N_REQ*SPI_DATA_W-1:0] req_wdata,
  input  logic [N_REQ-1:0]            req_read,
  output logic [N_REQ-1:0]            ack,
  output logic                        err,
  output logic [SPI_DATA_W-1:0]       rdata,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy,
  output logic [SPI_ADDR_W-1:0]       spi_addr,
  output logic [SPI_DATA_W-1:0]       spi_wdata,
  output logic                        spi_read,
  output logic                        spi_enable,
  input  logic                        spi_done,
  input  logic [SPI_DATA_W-1:0]       spi_rdata
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t             state_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic               done_q_reg;
  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               done_rise;

  logic [SPI_ADDR_W-1:0] slot_addr  [N_REQ];
  logic [SPI_DATA_W-1:0] slot_wdata [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    assign slot_addr[gi]  = req_addr[gi*SPI_ADDR_W +: SPI_ADDR_W];
    assign slot_wdata[gi] = req_wdata[gi*SPI_DATA_W +: SPI_DATA_W];
  end

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // Only a fresh rising edge completes; a level left over from the last transaction does not.
  assign done_rise = spi_done & ~done_q_reg;
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= IDX_W'(N_REQ - 1);
      done_q_reg  <= 1'b0;
      tmo_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      ack         <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      grant_id    <= '0;
      spi_addr    <= '0;
      spi_wdata   <= '0;
      spi_read    <= 1'b0;
      spi_enable  <= 1'b0;
    end else begin
      ack        <= '0;
      spi_enable <= 1'b0;
      done_q_reg <= spi_done;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            spi_addr   <= slot_addr[pick_idx];
            spi_wdata  <= slot_wdata[pick_idx];
            spi_read   <= req_read[pick_idx];
            grant_id   <= pick_idx;
            rr_ptr_reg <= pick_idx;
            spi_enable <= 1'b1;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt_reg <= '0;
          state_reg   <= BUSY;
        end
        BUSY: begin
          if (done_rise) begin
            rdata       <= spi_rdata;
            err         <= 1'b0;
            ack         <= N_REQ'(1) << grant_id;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            rdata       <= '0;
            err         <= 1'b1;
            ack         <= N_REQ'(1) << grant_id;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with N_REQ=2, GAP_CYCLES=8, TIMEOUT_CYCLES=64.
module tb_spi_arbiter;
  localparam int N   = 2;
  localparam int GAP = 8;
  localparam int TMO = 64;
  localparam int ENG = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req, req_read, ack;
  logic [15:0]  req_addr, req_wdata;
  logic         err, busy, spi_read, spi_enable, spi_done;
  logic [7:0]   rdata, spi_addr, spi_wdata, spi_rdata;
  logic [0:0]   grant_id;

  int n_cmp   = 0;
  int n_err   = 0;
  int cyc_cnt = 0;

  spi_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_read   (req_read),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .spi_addr   (spi_addr),
    .spi_wdata  (spi_wdata),
    .spi_read   (spi_read),
    .spi_enable (spi_enable),
    .spi_done   (spi_done),
    .spi_rdata  (spi_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_enable(input string tag, output int t);
    int n;
    n = 0;
    while (spi_enable !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_enable_seen"}, 32'(spi_enable), 32'd1);
    t = cyc_cnt;
  endtask

  initial begin
    int t_en, t_prev, n, seen, exp_g;
    t_prev = 0;
    reset = 1'b1; req = '0; req_read = '0; req_addr = '0; req_wdata = '0;
    spi_done = 1'b0; spi_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_ack",    32'(ack), 0);
    chk("rst_enable", 32'(spi_enable), 0);
    chk("rst_grant",  32'(grant_id), 0);
    chk("rst_rdata",  32'(rdata), 0);
    chk("rst_err",    32'(err), 0);
    chk("rst_addr",   32'(spi_addr), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Single read from requester 0; req dropped mid-transaction must not abort it.
    req_addr = {8'h00, 8'h1E}; req_read = 2'b01; req = 2'b01;
    @(negedge clk);
    chk("rd_latency", 32'(spi_enable), 1);
    chk("rd_addr",    32'(spi_addr), 32'h1E);
    chk("rd_read",    32'(spi_read), 1);
    chk("rd_grant",   32'(grant_id), 0);
    chk("rd_busy",    32'(busy), 1);
    req = 2'b00;
    @(negedge clk);
    chk("rd_pulse", 32'(spi_enable), 0);
    repeat (38) @(negedge clk);
    chk("rd_noack_early", 32'(ack), 0);
    spi_done = 1'b1; spi_rdata = 8'h03;
    @(negedge clk);
    chk("rd_ack",   32'(ack), 32'b01);
    chk("rd_rdata", 32'(rdata), 32'h03);
    chk("rd_err",   32'(err), 0);
    $display("txn read: grant=%0d addr=%02h ack=%b err=%b rdata=%02h", grant_id, spi_addr, ack, err, rdata);
    spi_done = 1'b0;
    @(negedge clk);
    chk("rd_ack_one_cycle", 32'(ack), 0);
    chk("rd_rdata_hold",    32'(rdata), 32'h03);

    // Write from requester 1.
    req_addr = {8'h10, 8'h1E}; req_wdata = {8'h50, 8'h00}; req_read = 2'b01; req = 2'b10;
    wait_enable("wr", t_en);
    chk("wr_addr",  32'(spi_addr), 32'h10);
    chk("wr_wdata", 32'(spi_wdata), 32'h50);
    chk("wr_read",  32'(spi_read), 0);
    chk("wr_grant", 32'(grant_id), 1);
    repeat (5) @(negedge clk);
    spi_done = 1'b1; spi_rdata = 8'hA5;
    @(negedge clk);
    chk("wr_ack",   32'(ack), 32'b10);
    chk("wr_err",   32'(err), 0);
    chk("wr_rdata", 32'(rdata), 32'hA5);
    $display("txn write: grant=%0d addr=%02h wdata=%02h ack=%b err=%b", grant_id, spi_addr, spi_wdata, ack, err);
    req = 2'b00; spi_done = 1'b0;

    // Contention: both requesters held high; last grant was 1, so 0,1,0,1.
    // Done is driven mid-cycle ENG cycles after enable; a clocked engine would have
    // raised it one edge earlier, so engine time is ENG-1.
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_enable("rr", t_en);
      exp_g = k % 2;
      chk("rr_grant", 32'(grant_id), 32'(exp_g));
      if (k > 0) chk("rr_spacing", 32'((t_en - t_prev) >= (ENG - 1 + GAP + 3)), 1);
      t_prev = t_en;
      repeat (ENG) @(negedge clk);
      spi_done = 1'b1; spi_rdata = 8'h30 + 8'(k);
      @(negedge clk);
      chk("rr_ack",   32'(ack), 32'(2'b01 << exp_g));
      chk("rr_rdata", 32'(rdata), 32'(8'h30 + 8'(k)));
      $display("txn rr%0d: grant=%0d ack=%b rdata=%02h enable_at=%0d", k, grant_id, ack, rdata, t_en);
      spi_done = 1'b0; req[exp_g] = 1'b0;
      @(negedge clk);
      req[exp_g] = 1'b1;
    end
    req = 2'b00;

    // Timeout: ISSUE cycle then 64 BUSY cycles; ack seen on the 65th sample after enable.
    req = 2'b01;
    wait_enable("to", t_en);
    n = 0;
    while (ack === 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'd65);
    chk("to_ack",    32'(ack), 32'b01);
    chk("to_err",    32'(err), 1);
    chk("to_rdata",  32'(rdata), 0);
    $display("txn timeout: grant=%0d ack=%b err=%b rdata=%02h after=%0d", grant_id, ack, err, rdata, n);
    req = 2'b00;

    // Normal service after the timeout; done then stays high into the next transaction.
    req = 2'b10;
    wait_enable("post_to", t_en);
    chk("post_to_grant", 32'(grant_id), 1);
    repeat (3) @(negedge clk);
    spi_done = 1'b1; spi_rdata = 8'h77;
    @(negedge clk);
    chk("post_to_ack",   32'(ack), 32'b10);
    chk("post_to_err",   32'(err), 0);
    chk("post_to_rdata", 32'(rdata), 32'h77);
    $display("txn post-timeout: grant=%0d ack=%b err=%b rdata=%02h", grant_id, ack, err, rdata);
    req = 2'b00;

    // Stale done: level high on BUSY entry must not complete.
    req = 2'b01;
    wait_enable("st", t_en);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack !== 2'b00) seen++;
    end
    chk("st_noack", 32'(seen), 0);
    spi_done = 1'b0;
    @(negedge clk);
    spi_done = 1'b1; spi_rdata = 8'h5A;
    @(negedge clk);
    chk("st_ack",   32'(ack), 32'b01);
    chk("st_rdata", 32'(rdata), 32'h5A);
    chk("st_err",   32'(err), 0);
    $display("txn stale-done: grant=%0d ack=%b err=%b rdata=%02h", grant_id, ack, err, rdata);
    req = 2'b00; spi_done = 1'b0;

    // Asynchronous reset mid-BUSY, then requester 0 must win first again.
    req = 2'b01;
    wait_enable("rs", t_en);
    repeat (3) @(negedge clk);
    chk("rs_busy_pre", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("rs_busy",   32'(busy), 0);
    chk("rs_enable", 32'(spi_enable), 0);
    chk("rs_ack",    32'(ack), 0);
    req = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rs_first_enable", 32'(spi_enable), 1);
    chk("rs_first_grant",  32'(grant_id), 0);
    repeat (3) @(negedge clk);
    spi_done = 1'b1; spi_rdata = 8'h11;
    @(negedge clk);
    chk("rs_ack_after", 32'(ack), 32'b01);
    $display("txn after-reset: grant=%0d ack=%b err=%b rdata=%02h", grant_id, ack, err, rdata);
    req = 2'b00; spi_done = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
